// File: rtl/exp_table_scheduler.sv
// exp_table_scheduler
// Shares one exp(x*sigma) table generator between NREQ requesters. A round-robin
// arbiter picks a requester, its sigma is latched for the generator, a one-cycle
// start pulse launches the run, and every streamed sample is written into that
// requester's bank of the shared table RAM. Completion, short/long runs and
// generator timeouts are reported back.
//
// Ports
//   CLK, RST    clock and synchronous active-high reset
//   iReq        level request per requester, held until its oGrant
//   iSigma      packed sigma per requester, slice i = [18*i+17:18*i]
//   oGrant      one-cycle pulse: request accepted, sigma sampled
//   oReqDone    one-cycle pulse: bank table complete
//   oReqErr     pulses with oReqDone when sample count != TABLE_LEN
//   oFatal      sticky generator timeout flag, cleared only by RST
//   oBusy       high in every state except IDLE
//   oGenStart   one-cycle generator start pulse
//   oGenSigma   sigma presented to the generator
//   iGenData, iGenAddr, iGenValid, iGenDone   generator sample stream
//   oWrEn, oWrAddr, oWrData                   table RAM write port
module exp_table_scheduler #(
    parameter int NREQ       = 4,
    parameter int PATH_WIDTH = 10,
    parameter int X_MIN      = -307,
    parameter int X_MAX      = 280,
    parameter int TIMEOUT    = 1023,
    parameter int BANK_W     = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              iReq,
    input  logic [18*NREQ-1:0]           iSigma,
    output logic [NREQ-1:0]              oGrant,
    output logic [NREQ-1:0]              oReqDone,
    output logic                         oReqErr,
    output logic                         oFatal,
    output logic                         oBusy,
    output logic                         oGenStart,
    output logic [17:0]                  oGenSigma,
    input  logic [17:0]                  iGenData,
    input  logic [PATH_WIDTH-1:0]        iGenAddr,
    input  logic                         iGenValid,
    input  logic                         iGenDone,
    output logic                         oWrEn,
    output logic [BANK_W+PATH_WIDTH-1:0] oWrAddr,
    output logic [17:0]                  oWrData
);

    localparam int CNT_W     = 10;
    localparam int TABLE_LEN = X_MAX - X_MIN + 1;
    localparam logic [CNT_W-1:0]        TABLE_LEN_C = CNT_W'(TABLE_LEN);
    localparam logic [CNT_W-1:0]        TIMER_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [PATH_WIDTH-1:0]   TABLE_LEN_A = PATH_WIDTH'(TABLE_LEN);
    localparam logic signed [PATH_WIDTH:0] X_MIN_S  = (PATH_WIDTH+1)'(X_MIN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_COOL,
        ST_HALT
    } state_t;

    state_t                     state_reg, state_next;
    logic [BANK_W-1:0]          ptr_reg, ptr_next;
    logic [BANK_W-1:0]          id_reg, id_next;
    logic [17:0]                sigma_reg, sigma_next;
    logic [NREQ-1:0]            grant_reg, grant_next;
    logic [NREQ-1:0]            done_reg, done_next;
    logic                       err_reg, err_next;
    logic                       fatal_reg, fatal_next;
    logic [CNT_W-1:0]           count_reg, count_next;
    logic [CNT_W-1:0]           timer_reg, timer_next;
    logic                       cool_reg, cool_next;
    logic                       wr_en_reg, wr_en_next;
    logic [BANK_W+PATH_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [17:0]                wr_data_reg, wr_data_next;
    logic                       gen_start, busy;

    // Per-requester sigma view of the packed input bus.
    logic [17:0] sigma_arr [NREQ];
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sigma
            assign sigma_arr[gi] = iSigma[18*gi +: 18];
        end
    endgenerate

    // Round-robin search: candidates ptr, ptr+1, ... (wrapping). The loop runs
    // from the farthest candidate down so the nearest requesting one wins.
    logic [BANK_W-1:0] arb_cand;
    logic [BANK_W-1:0] arb_id;
    logic              arb_found;
    always_comb begin
        arb_cand  = '0;
        arb_id    = '0;
        arb_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            arb_cand = ptr_reg + BANK_W'(i);
            if (iReq[arb_cand]) begin
                arb_found = 1'b1;
                arb_id    = arb_cand;
            end
        end
    end

    // Table offset in one extra signed bit so addresses below X_MIN show up
    // as negative and are rejected along with those past the table end.
    logic signed [PATH_WIDTH:0] offset_s;
    logic [PATH_WIDTH-1:0]      offset_u;
    logic                       in_range;
    logic [CNT_W-1:0]           count_inc;
    assign offset_s  = $signed({iGenAddr[PATH_WIDTH-1], iGenAddr}) - X_MIN_S;
    assign offset_u  = offset_s[PATH_WIDTH-1:0];
    assign in_range  = !offset_s[PATH_WIDTH] && (offset_u < TABLE_LEN_A);
    assign count_inc = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        id_next      = id_reg;
        sigma_next   = sigma_reg;
        grant_next   = '0;
        done_next    = '0;
        err_next     = 1'b0;
        fatal_next   = fatal_reg;
        count_next   = count_reg;
        timer_next   = timer_reg;
        cool_next    = cool_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        gen_start    = 1'b0;
        busy         = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (arb_found) begin
                    id_next            = arb_id;
                    sigma_next         = sigma_arr[arb_id];
                    grant_next[arb_id] = 1'b1;
                    ptr_next           = arb_id + BANK_W'(1);
                    state_next         = ST_START;
                end
            end
            ST_START: begin
                gen_start  = 1'b1;
                count_next = '0;
                timer_next = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                timer_next = timer_reg + CNT_W'(1);
                if (iGenValid) begin
                    // Out-of-range samples still count so the run is flagged.
                    count_next = count_inc;
                    if (in_range) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = {id_reg, offset_u};
                        wr_data_next = iGenData;
                    end
                end
                if (iGenDone) begin
                    done_next[id_reg] = 1'b1;
                    err_next          = (count_next != TABLE_LEN_C);
                    cool_next         = 1'b0;
                    state_next        = ST_COOL;
                end else if (timer_reg == TIMER_LAST) begin
                    fatal_next = 1'b1;
                    state_next = ST_HALT;
                end
            end
            ST_COOL: begin
                // Two cycles so the generator reloads X_MIN before the next start.
                if (cool_reg) begin
                    state_next = ST_IDLE;
                end else begin
                    cool_next = 1'b1;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            id_reg      <= '0;
            sigma_reg   <= '0;
            grant_reg   <= '0;
            done_reg    <= '0;
            err_reg     <= 1'b0;
            fatal_reg   <= 1'b0;
            count_reg   <= '0;
            timer_reg   <= '0;
            cool_reg    <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            id_reg      <= id_next;
            sigma_reg   <= sigma_next;
            grant_reg   <= grant_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            fatal_reg   <= fatal_next;
            count_reg   <= count_next;
            timer_reg   <= timer_next;
            cool_reg    <= cool_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    assign oGrant    = grant_reg;
    assign oReqDone  = done_reg;
    assign oReqErr   = err_reg;
    assign oFatal    = fatal_reg;
    assign oBusy     = busy;
    assign oGenStart = gen_start;
    assign oGenSigma = sigma_reg;
    assign oWrEn     = wr_en_reg;
    assign oWrAddr   = wr_addr_reg;
    assign oWrData   = wr_data_reg;

endmodule

// File: tb/tb_exp_table_scheduler.sv
// Directed bench for exp_table_scheduler. Expected RAM writes are queued when a
// generator sample is driven and popped by a monitor when oWrEn is seen.
module tb_exp_table_scheduler;

    localparam int XMIN = -307;
    localparam int XMAX = 280;
    localparam int TLEN = 588;

    localparam logic [17:0] SIG0 = 18'h20000;
    localparam logic [17:0] SIG1 = 18'h01234;
    localparam logic [17:0] SIG2 = 18'h0C000;
    localparam logic [17:0] SIG3 = 18'h0A0A0;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  iReq;
    logic [71:0] iSigma;
    logic [3:0]  oGrant;
    logic [3:0]  oReqDone;
    logic        oReqErr;
    logic        oFatal;
    logic        oBusy;
    logic        oGenStart;
    logic [17:0] oGenSigma;
    logic [17:0] iGenData;
    logic [9:0]  iGenAddr;
    logic        iGenValid;
    logic        iGenDone;
    logic        oWrEn;
    logic [11:0] oWrAddr;
    logic [17:0] oWrData;

    exp_table_scheduler dut (
        .CLK       (CLK),
        .RST       (RST),
        .iReq      (iReq),
        .iSigma    (iSigma),
        .oGrant    (oGrant),
        .oReqDone  (oReqDone),
        .oReqErr   (oReqErr),
        .oFatal    (oFatal),
        .oBusy     (oBusy),
        .oGenStart (oGenStart),
        .oGenSigma (oGenSigma),
        .iGenData  (iGenData),
        .iGenAddr  (iGenAddr),
        .iGenValid (iGenValid),
        .iGenDone  (iGenDone),
        .oWrEn     (oWrEn),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] addr;
        logic [17:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every RAM write must match the oldest expected one.
    always @(negedge CLK) begin
        if (oWrEn === 1'b1) begin
            check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(oWrAddr), 32'(mon_e.addr));
                check("wr_data", 32'(oWrData), 32'(mon_e.data));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int bank, input int addr, input logic [17:0] data);
        int  off;
        wr_t e;
        off = addr - XMIN;
        if (off >= 0 && off < TLEN) begin
            e.addr = {2'(bank), 10'(off)};
            e.data = data;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_grant(input logic [3:0] exp_grant, input logic [17:0] exp_sigma, input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while (oGrant == 4'd0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_grant"}, 32'(oGrant), 32'(exp_grant));
        check({tag, "_genstart"}, 32'(oGenStart), 32'd1);
        check({tag, "_sigma"}, 32'(oGenSigma), 32'(exp_sigma));
        iReq = iReq & ~exp_grant;
    endtask

    // Completion pulse, two-cycle cool-down and return to IDLE.
    task automatic finish_run(input int bank, input logic [17:0] sigma, input bit exp_err, input string tag);
        tick();
        iGenValid = 1'b0;
        iGenDone  = 1'b0;
        @(negedge CLK);
        check({tag, "_done"}, 32'(oReqDone), 32'(4'b0001 << bank));
        check({tag, "_err"}, 32'(oReqErr), 32'(exp_err));
        check({tag, "_sigma_hold"}, 32'(oGenSigma), 32'(sigma));
        @(negedge CLK);
        check({tag, "_done_1cyc"}, 32'(oReqDone), 32'd0);
        check({tag, "_cool_busy"}, 32'(oBusy), 32'd1);
        @(negedge CLK);
        check({tag, "_idle"}, 32'(oBusy), 32'd0);
        check({tag, "_all_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic gen_run(input int n, input int start, input bit give_done, input int bank,
                           input logic [17:0] sigma, input bit exp_err, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            iGenValid = 1'b1;
            iGenAddr  = 10'(start + i);
            iGenData  = 18'($urandom);
            iGenDone  = give_done && (i == n - 1);
            push_exp(bank, start + i, iGenData);
            if (i == 0) begin
                @(negedge CLK);
                check({tag, "_start_1cyc"}, 32'(oGenStart), 32'd0);
                check({tag, "_grant_1cyc"}, 32'(oGrant), 32'd0);
                check({tag, "_run_busy"}, 32'(oBusy), 32'd1);
            end
        end
        finish_run(bank, sigma, exp_err, tag);
    endtask

    initial begin
        int n;
        logic [3:0] g;

        iReq      = 4'd0;
        iSigma    = {SIG3, SIG2, SIG1, SIG0};
        iGenData  = '0;
        iGenAddr  = '0;
        iGenValid = 1'b0;
        iGenDone  = 1'b0;
        RST       = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_out", {oGrant, oReqDone, oReqErr, oFatal, oBusy, oGenStart, oGenSigma}, 32'd0);
        check("rst_wr", {oWrEn, oWrAddr, oWrData}, 32'd0);
        tick();
        RST = 1'b0;

        // 1: single request, full 588-sample table into bank 2
        iReq = 4'b0100;
        wait_grant(4'b0100, SIG2, "t1");
        gen_run(TLEN, XMIN, 1'b1, 2, SIG2, 1'b0, "t1");
        $display("t1 full table bank2 done");

        // 2: requests 0,1,3 held from reset -> RR order 0,1,3, then 0 again
        RST  = 1'b1;
        iReq = 4'b1011;
        tick();
        tick();
        RST = 1'b0;
        wait_grant(4'b0001, SIG0, "t2a");
        gen_run(4, XMIN, 1'b1, 0, SIG0, 1'b1, "t2a");
        wait_grant(4'b0010, SIG1, "t2b");
        gen_run(4, XMIN, 1'b1, 1, SIG1, 1'b1, "t2b");
        wait_grant(4'b1000, SIG3, "t2c");
        gen_run(4, XMIN, 1'b1, 3, SIG3, 1'b1, "t2c");
        iReq[0] = 1'b1;
        wait_grant(4'b0001, SIG0, "t2d");
        gen_run(4, XMIN, 1'b1, 0, SIG0, 1'b1, "t2d");
        $display("t2 round robin 0,1,3,0 done");

        // 3: short run (587) flags error; next request with edge addresses still served
        iReq = 4'b0010;
        wait_grant(4'b0010, SIG1, "t3a");
        gen_run(TLEN - 1, XMIN, 1'b1, 1, SIG1, 1'b1, "t3a");
        iReq = 4'b1000;
        wait_grant(4'b1000, SIG3, "t3b");
        gen_run(3, XMAX - 1, 1'b1, 3, SIG3, 1'b1, "t3b");
        $display("t3 short run and out-of-range address done");

        // 4: generator never finishes -> fatal after 1023 RUN cycles, then halt
        iReq = 4'b0001;
        wait_grant(4'b0001, SIG0, "t4");
        n = 0;
        while (!oFatal && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("t4_fatal_delay", 32'(n), 32'd1024);
        check("t4_fatal", 32'(oFatal), 32'd1);
        iReq = 4'b1111;
        g    = 4'd0;
        repeat (20) begin
            @(negedge CLK);
            g = g | oGrant;
        end
        check("t4_no_grant", 32'(g), 32'd0);
        check("t4_halt_busy", 32'(oBusy), 32'd1);
        check("t4_fatal_sticky", 32'(oFatal), 32'd1);
        iReq = 4'd0;
        RST  = 1'b1;
        @(negedge CLK);
        check("t4_rst_out", {oGrant, oReqDone, oReqErr, oFatal, oBusy, oGenStart, oGenSigma}, 32'd0);
        check("t4_rst_wr", {oWrEn, oWrAddr, oWrData}, 32'd0);
        tick();
        RST = 1'b0;
        $display("t4 timeout fatal and recovery done");

        // 5: reset mid-run, new request rides the rest of the old generator run
        iReq = 4'b0100;
        wait_grant(4'b0100, SIG2, "t5a");
        for (int i = 0; i < TLEN; i++) begin
            tick();
            iGenValid = 1'b1;
            iGenAddr  = 10'(XMIN + i);
            iGenData  = 18'($urandom);
            iGenDone  = (i == TLEN - 1);
            if (i < 100) push_exp(2, XMIN + i, iGenData);
            else if (i >= 103) push_exp(1, XMIN + i, iGenData);
            if (i == 100) RST = 1'b1;
            if (i == 101) begin
                RST  = 1'b0;
                iReq = 4'b0010;
                @(negedge CLK);
                check("t5_rst_idle", 32'(oBusy), 32'd0);
                check("t5_rst_nowr", 32'(oWrEn), 32'd0);
            end
            if (i == 102) begin
                @(negedge CLK);
                check("t5b_grant", 32'(oGrant), 32'b0010);
                check("t5b_genstart", 32'(oGenStart), 32'd1);
                check("t5b_sigma", 32'(oGenSigma), 32'(SIG1));
                iReq = 4'd0;
            end
        end
        finish_run(1, SIG1, 1'b1, "t5b");
        $display("t5 reset mid-run done");

        // 6: generator activity while IDLE is ignored
        for (int i = 0; i < 10; i++) begin
            tick();
            iGenValid = i[0];
            iGenDone  = i[1];
            iGenAddr  = 10'($urandom);
            iGenData  = 18'($urandom);
            @(negedge CLK);
            check("t6_nowr", 32'(oWrEn), 32'd0);
            check("t6_idle", {oBusy, oReqDone, oGenStart}, 32'd0);
        end
        iGenValid = 1'b0;
        iGenDone  = 1'b0;
        $display("t6 idle generator noise done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
